// File: rtl/serial_bus_pkg.sv
// Shared serial-bus definitions: arbiter state encoding and sizing limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_bus_pkg;

    // Upper bound on the number of masters one arbiter instance may serve.
    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANT        = 2'd1,
        SPLIT_RESUME = 2'd2
    } arb_state_t;

endpackage : serial_bus_pkg

// File: rtl/split_bus_arbiter_if.sv
// Bundle of arbiter-facing bus signals: master requests, split handshake, grants.
// Latency: n/a (wiring only).
// Backpressure: requests are level-held; grants are the only flow control.
// Ports: m_req/bus_split_ack/split_req flow toward the arbiter; m_grant,
//        split_grant, bus_owner, bus_busy, m_split_wait, split_err flow back.
interface split_bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = $clog2(N_MASTERS)
);
    logic [N_MASTERS-1:0] m_req;
    logic                 bus_split_ack;
    logic                 split_req;
    logic [N_MASTERS-1:0] m_grant;
    logic                 split_grant;
    logic [IDX_W-1:0]     bus_owner;
    logic                 bus_busy;
    logic [N_MASTERS-1:0] m_split_wait;
    logic                 split_err;

    // Arbiter side.
    modport slave (
        input  m_req, bus_split_ack, split_req,
        output m_grant, split_grant, bus_owner, bus_busy, m_split_wait, split_err
    );

    // Requester / target side.
    modport master (
        output m_req, bus_split_ack, split_req,
        input  m_grant, split_grant, bus_owner, bus_busy, m_split_wait, split_err
    );
endinterface : split_bus_arbiter_if

// File: rtl/rr_priority_picker.sv
// Round-robin winner search: first set bit of req after index last, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; win_vld low when no request is set.
// Ports: req (request vector), last (previous winner) -> win_idx, win_vld.
module rr_priority_picker #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [IDX_W-1:0]     win_idx,
    output logic                 win_vld
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // last is the one left standing; offset N_MASTERS lands on last itself.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = (int'(last) + i) % N_MASTERS;
            if (req[idx]) begin
                win_idx = IDX_W'(idx);
                win_vld = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker

// File: rtl/split_bus_arbiter.sv
// Round-robin bus arbiter that parks a master on split ack and resumes it with the target.
// Latency: request/release/split/resume each take effect one clock after being sampled.
// Backpressure: masters hold m_req until granted; a parked master is masked until resume completes.
// Ports: clk, rst_n (async, active-low); bus = slave modport carrying requests, split
//        handshake in, and grants, owner, busy, park status and error pulse out.
module split_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    split_bus_arbiter_if.slave   bus
);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic                 split_pending_q, split_pending_d;
    logic [IDX_W-1:0]     split_owner_q, split_owner_d;
    logic [N_MASTERS-1:0] m_grant_q, m_grant_d;
    logic                 split_grant_q, split_grant_d;
    logic                 split_err_q, split_err_d;

    logic [N_MASTERS-1:0] split_wait;
    logic [N_MASTERS-1:0] eligible;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    assign split_wait = split_pending_q ? (N_MASTERS'(1) << split_owner_q) : '0;
    assign eligible   = bus.m_req & ~split_wait;

    rr_priority_picker #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req     (eligible),
        .last    (last_owner_q),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        m_grant_d       = m_grant_q;
        split_grant_d   = split_grant_q;
        split_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.split_req && split_pending_q) begin
                    // Resumption beats every new request.
                    state_d       = SPLIT_RESUME;
                    owner_d       = split_owner_q;
                    split_grant_d = 1'b1;
                    m_grant_d     = N_MASTERS'(1) << split_owner_q;
                end else begin
                    // A resume request with nothing parked is flagged, then ignored.
                    if (bus.split_req) begin
                        split_err_d = 1'b1;
                    end
                    if (pick_vld) begin
                        state_d      = GRANT;
                        owner_d      = pick_idx;
                        last_owner_d = pick_idx;
                        m_grant_d    = N_MASTERS'(1) << pick_idx;
                    end
                end
            end

            GRANT: begin
                if (bus.bus_split_ack) begin
                    // Only one split may be outstanding; a second one releases
                    // the owner but leaves the existing record alone.
                    if (split_pending_q) begin
                        split_err_d = 1'b1;
                    end else begin
                        split_pending_d = 1'b1;
                        split_owner_d   = owner_q;
                    end
                    m_grant_d = '0;
                    state_d   = IDLE;
                end else if (!bus.m_req[owner_q]) begin
                    m_grant_d = '0;
                    state_d   = IDLE;
                end
            end

            SPLIT_RESUME: begin
                if (bus.bus_split_ack) begin
                    split_err_d = 1'b1;
                end
                if (!bus.split_req) begin
                    split_pending_d = 1'b0;
                    split_grant_d   = 1'b0;
                    m_grant_d       = '0;
                    state_d         = IDLE;
                end
            end

            default: begin
                state_d       = IDLE;
                m_grant_d     = '0;
                split_grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            owner_q         <= '0;
            last_owner_q    <= IDX_W'(N_MASTERS - 1);
            split_pending_q <= 1'b0;
            split_owner_q   <= '0;
            m_grant_q       <= '0;
            split_grant_q   <= 1'b0;
            split_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            m_grant_q       <= m_grant_d;
            split_grant_q   <= split_grant_d;
            split_err_q     <= split_err_d;
        end
    end

    assign bus.m_grant      = m_grant_q;
    assign bus.split_grant  = split_grant_q;
    assign bus.bus_owner    = owner_q;
    assign bus.bus_busy     = (state_q != IDLE);
    assign bus.m_split_wait = split_wait;
    assign bus.split_err    = split_err_q;

endmodule : split_bus_arbiter

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter with two masters.
// Latency: inputs change 1ns after a rising edge and outputs are checked there.
// Backpressure: n/a.
module tb_split_bus_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    split_bus_arbiter_if #(.N_MASTERS(2)) bif ();

    split_bus_arbiter #(.N_MASTERS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bif.m_req         = 2'b00;
        bif.bus_split_ack = 1'b0;
        bif.split_req     = 1'b0;

        // Reset state.
        #2;
        chk("rst_grant",  bif.m_grant, 2'b00);
        chk("rst_sgrant", bif.split_grant, 0);
        chk("rst_owner",  bif.bus_owner, 0);
        chk("rst_busy",   bif.bus_busy, 0);
        chk("rst_wait",   bif.m_split_wait, 2'b00);
        chk("rst_err",    bif.split_err, 0);
        #10;
        rst_n = 1'b1;

        // Round-robin rotation: 0,1,0,1, one idle cycle between grants.
        bif.m_req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            chk("rr_grant", bif.m_grant, exp_g);
            chk("rr_owner", bif.bus_owner, r % 2);
            chk("rr_busy",  bif.bus_busy, 1);
            tick();
            chk("rr_hold1", bif.m_grant, exp_g);
            tick();
            chk("rr_hold2", bif.m_grant, exp_g);
            bif.m_req = 2'b11 & ~exp_g;
            tick();
            chk("rr_idle_grant", bif.m_grant, 2'b00);
            chk("rr_idle_busy",  bif.bus_busy, 0);
            bif.m_req = 2'b11;
        end
        bif.m_req = 2'b00;
        tick();
        chk("rr_end", bif.m_grant, 2'b00);

        // Split park and resume.
        bif.m_req = 2'b01;
        tick();
        chk("sp_grant0", bif.m_grant, 2'b01);
        bif.bus_split_ack = 1'b1;
        tick();
        bif.bus_split_ack = 1'b0;
        chk("sp_park_grant", bif.m_grant, 2'b00);
        chk("sp_park_wait",  bif.m_split_wait, 2'b01);
        chk("sp_park_err",   bif.split_err, 0);
        bif.m_req = 2'b11;
        tick();
        chk("sp_m1_grant", bif.m_grant, 2'b10);
        chk("sp_m1_owner", bif.bus_owner, 1);
        tick();
        chk("sp_m1_hold", bif.m_grant, 2'b10);
        bif.m_req = 2'b01;
        tick();
        chk("sp_m1_rel", bif.m_grant, 2'b00);
        bif.split_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sp_res_sgrant", bif.split_grant, 1);
            chk("sp_res_grant",  bif.m_grant, 2'b01);
            chk("sp_res_owner",  bif.bus_owner, 0);
        end
        bif.split_req = 1'b0;
        tick();
        chk("sp_done_sgrant", bif.split_grant, 0);
        chk("sp_done_grant",  bif.m_grant, 2'b00);
        chk("sp_done_wait",   bif.m_split_wait, 2'b00);
        tick();
        chk("sp_m0_again", bif.m_grant, 2'b01);
        bif.m_req = 2'b00;
        tick();
        chk("sp_m0_rel", bif.m_grant, 2'b00);

        // Resume priority over a new request.
        bif.m_req = 2'b01;
        tick();
        chk("pr_grant0", bif.m_grant, 2'b01);
        bif.bus_split_ack = 1'b1;
        tick();
        bif.bus_split_ack = 1'b0;
        chk("pr_wait", bif.m_split_wait, 2'b01);
        bif.m_req     = 2'b10;
        bif.split_req = 1'b1;
        tick();
        chk("pr_sgrant", bif.split_grant, 1);
        chk("pr_grant",  bif.m_grant, 2'b01);
        tick();
        chk("pr_hold", bif.m_grant, 2'b01);
        bif.split_req = 1'b0;
        tick();
        chk("pr_rel", bif.m_grant, 2'b00);
        tick();
        chk("pr_m1", bif.m_grant, 2'b10);
        bif.m_req = 2'b00;
        tick();
        chk("pr_m1_rel", bif.m_grant, 2'b00);

        // Spurious resume: error pulse, master 0 still granted.
        bif.m_req     = 2'b01;
        bif.split_req = 1'b1;
        tick();
        chk("sv_err",    bif.split_err, 1);
        chk("sv_grant",  bif.m_grant, 2'b01);
        chk("sv_sgrant", bif.split_grant, 0);
        bif.split_req = 1'b0;
        tick();
        chk("sv_err_off", bif.split_err, 0);
        chk("sv_hold",    bif.m_grant, 2'b01);

        // Second split while one is pending.
        bif.bus_split_ack = 1'b1;
        tick();
        bif.bus_split_ack = 1'b0;
        chk("ds_wait1", bif.m_split_wait, 2'b01);
        chk("ds_err1",  bif.split_err, 0);
        bif.m_req = 2'b11;
        tick();
        chk("ds_m1", bif.m_grant, 2'b10);
        bif.bus_split_ack = 1'b1;
        tick();
        bif.bus_split_ack = 1'b0;
        chk("ds_err2",  bif.split_err, 1);
        chk("ds_rel",   bif.m_grant, 2'b00);
        chk("ds_wait2", bif.m_split_wait, 2'b01);
        bif.m_req = 2'b01;
        tick();
        chk("ds_err_off", bif.split_err, 0);
        chk("ds_masked",  bif.m_grant, 2'b00);

        // Split ack during resume is an error, resume continues.
        bif.split_req = 1'b1;
        tick();
        chk("ra_sgrant", bif.split_grant, 1);
        chk("ra_grant",  bif.m_grant, 2'b01);
        bif.bus_split_ack = 1'b1;
        tick();
        bif.bus_split_ack = 1'b0;
        chk("ra_err",    bif.split_err, 1);
        chk("ra_sgrant2", bif.split_grant, 1);
        tick();
        chk("ra_err_off", bif.split_err, 0);

        // Async reset in the middle of a resume.
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant",  bif.m_grant, 2'b00);
        chk("ar_sgrant", bif.split_grant, 0);
        chk("ar_busy",   bif.bus_busy, 0);
        chk("ar_wait",   bif.m_split_wait, 2'b00);
        chk("ar_owner",  bif.bus_owner, 0);
        #3;
        rst_n         = 1'b1;
        bif.split_req = 1'b0;
        bif.m_req     = 2'b11;
        tick();
        chk("ar_first", bif.m_grant, 2'b01);
        chk("ar_wait2", bif.m_split_wait, 2'b00);
        bif.m_req = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_split_bus_arbiter
